// File: rtl/gaussian_noise_gen_multi.sv
// gaussian_noise_gen_multi
//   Simulated ADC noise source. Each of NSAMP samples is the sum of NSUM
//   centred uniform terms taken from independent 32-bit Galois LFSRs
//   (central-limit approximation). A runtime arithmetic shift attenuates
//   the sum, and the result is saturated to SAMP_W bits and then
//   sign-extended to OUT_W.
//   Optional macro GAUSS_SAT_CNT_EN adds sat_cnt_o, a saturating count of
//   clipped samples.
// Ports:
//   clk          clock
//   rst_n_i      async active-low reset
//   seed_i       seed applied on seed_load_i
//   seed_load_i  reseed all LFSRs and flush both pipeline stages
//   run_i        generate words while high
//   shift_i      arithmetic right shift applied to each sum
//   sim_data     sample s in [s*OUT_W +: OUT_W]
//   sim_valid    sim_data holds an unaccepted word
//   sim_ready    downstream accepts the word
//   sat_cnt_o    (GAUSS_SAT_CNT_EN only) clipped-sample count

// One sample slot: NSUM LFSRs, the stage-B sum and the stage-C output register.
module gauss_lane #(
    parameter int          SAMP_W    = 12,
    parameter int          OUT_W     = 16,
    parameter int          NSUM      = 4,
    parameter int          LANE      = 0,
    parameter logic [47:0] SEED_BASE = 48'h0
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic [47:0]       seed_i,
    input  logic              seed_load_i,
    input  logic              step,
    input  logic              ld_c,
    input  logic [3:0]        shift_i,
    output logic [OUT_W-1:0]  samp
`ifdef GAUSS_SAT_CNT_EN
    ,
    output logic              clip
`endif
);
    localparam int SW   = SAMP_W + $clog2(NSUM);
    localparam int MAXI = 2**(SAMP_W-1) - 1;
    localparam logic signed [SW-1:0] MAX_V = SW'(MAXI);
    localparam logic signed [SW-1:0] MIN_V = SW'(-MAXI - 1);
    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] TAPS = 32'h8020_0003;

    function automatic logic [31:0] seed_of(input logic [47:0] s, input int k);
        logic [31:0] v;
        v = s[31:0] ^ {s[47:32], 16'h0} ^ (32'(k + 1) * 32'h9E37_79B9);
        return (v == 32'h0) ? 32'h1 : v;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    endfunction

    logic [NSUM-1:0][31:0]  lfsr;
    logic signed [SW-1:0]   sum_c, sum_b, shd;
    logic signed [SAMP_W-1:0] sat_v;
    logic                   clip_hi, clip_lo;

    // Inverting the top bit of the unsigned term is the same as subtracting 2^(SAMP_W-1).
    always_comb begin
        sum_c = '0;
        for (int j = 0; j < NSUM; j++)
            sum_c = sum_c + SW'($signed({~lfsr[j][31], lfsr[j][30:32-SAMP_W]}));
    end

    always_comb begin
        shd     = sum_b >>> shift_i;
        clip_hi = shd > MAX_V;
        clip_lo = shd < MIN_V;
        sat_v   = clip_hi ? MAX_V[SAMP_W-1:0] :
                  clip_lo ? MIN_V[SAMP_W-1:0] : shd[SAMP_W-1:0];
    end

`ifdef GAUSS_SAT_CNT_EN
    assign clip = clip_hi | clip_lo;
`endif

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int j = 0; j < NSUM; j++) lfsr[j] <= seed_of(SEED_BASE, LANE*NSUM + j);
        end else if (seed_load_i) begin
            for (int j = 0; j < NSUM; j++) lfsr[j] <= seed_of(seed_i, LANE*NSUM + j);
        end else if (step) begin
            for (int j = 0; j < NSUM; j++) lfsr[j] <= lfsr_next(lfsr[j]);
        end
    end

    // Only real words are loaded, so sim_data stays put while idle or flushed.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sum_b <= '0;
            samp  <= '0;
        end else if (!seed_load_i) begin
            if (step) sum_b <= sum_c;
            if (ld_c) samp  <= OUT_W'(sat_v);
        end
    end
endmodule

module gaussian_noise_gen_multi #(
    parameter int          NSAMP     = 8,
    parameter int          SAMP_W    = 12,
    parameter int          OUT_W     = 16,
    parameter int          NSUM      = 4,
    parameter logic [47:0] SEED_BASE = 48'h0
) (
    input  logic                    clk,
    input  logic                    rst_n_i,
    input  logic [47:0]             seed_i,
    input  logic                    seed_load_i,
    input  logic                    run_i,
    input  logic [3:0]              shift_i,
    output logic [NSAMP*OUT_W-1:0]  sim_data,
    output logic                    sim_valid,
    input  logic                    sim_ready
`ifdef GAUSS_SAT_CNT_EN
    ,
    output logic [31:0]             sat_cnt_o
`endif
);
    // vld_pipe[1] = stage B valid, vld_pipe[2] = sim_valid
    logic [2:1]                   vld_pipe;
    logic                         adv, step, ld_c;
    logic [NSAMP-1:0][OUT_W-1:0]  samp;

    assign adv       = !vld_pipe[2] || sim_ready;
    assign step      = adv && run_i;
    assign ld_c      = adv && vld_pipe[1];
    assign sim_valid = vld_pipe[2];
    assign sim_data  = samp;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i)         vld_pipe <= '0;
        else if (seed_load_i) vld_pipe <= '0;
        else if (adv)         vld_pipe <= {vld_pipe[1], run_i};
    end

`ifdef GAUSS_SAT_CNT_EN
    localparam int CW = $clog2(NSAMP + 1);
    logic [NSAMP-1:0] clip;
    logic [CW-1:0]    n_clip;
    logic [32:0]      cnt_sum;

    always_comb begin
        n_clip = '0;
        for (int s = 0; s < NSAMP; s++) n_clip = n_clip + CW'(clip[s]);
        cnt_sum = {1'b0, sat_cnt_o} + 33'(n_clip);
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i)         sat_cnt_o <= '0;
        else if (seed_load_i) sat_cnt_o <= '0;
        else if (ld_c)        sat_cnt_o <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
`endif

    for (genvar s = 0; s < NSAMP; s++) begin : g_lane
        gauss_lane #(
            .SAMP_W(SAMP_W), .OUT_W(OUT_W), .NSUM(NSUM), .LANE(s), .SEED_BASE(SEED_BASE)
        ) u_lane (
            .clk(clk), .rst_n_i(rst_n_i), .seed_i(seed_i), .seed_load_i(seed_load_i),
            .step(step), .ld_c(ld_c), .shift_i(shift_i), .samp(samp[s])
`ifdef GAUSS_SAT_CNT_EN
            , .clip(clip[s])
`endif
        );
    end
endmodule

// File: tb/tb_gaussian_noise_gen_multi.sv
// Testbench for gaussian_noise_gen_multi: word-level reference model
// (LFSR bank + sum/shift/clip in plain integer arithmetic) and an
// in-order scoreboard; backpressure and run_i gaps must not change the
// accepted word sequence.
module tb_gaussian_noise_gen_multi;
    localparam int          NSAMP     = 8;
    localparam int          SAMP_W    = 12;
    localparam int          OUT_W     = 16;
    localparam int          NSUM      = 4;
    localparam logic [47:0] SEED_BASE = 48'h0;
    localparam int          DW        = NSAMP*OUT_W;
    localparam int          HALF      = 2**(SAMP_W-1);
    localparam int          NL        = NSAMP*NSUM;

    logic          clk = 1'b0;
    logic          rst_n_i, seed_load_i, run_i, sim_ready;
    logic [47:0]   seed_i;
    logic [3:0]    shift_i;
    wire [DW-1:0]  sim_data;
    wire           sim_valid;
`ifdef GAUSS_SAT_CNT_EN
    wire [31:0]    sat_cnt_o;
`endif

    always #5 clk = ~clk;

    gaussian_noise_gen_multi #(
        .NSAMP(NSAMP), .SAMP_W(SAMP_W), .OUT_W(OUT_W), .NSUM(NSUM), .SEED_BASE(SEED_BASE)
    ) dut (
        .clk(clk), .rst_n_i(rst_n_i), .seed_i(seed_i), .seed_load_i(seed_load_i),
        .run_i(run_i), .shift_i(shift_i), .sim_data(sim_data), .sim_valid(sim_valid),
        .sim_ready(sim_ready)
`ifdef GAUSS_SAT_CNT_EN
        , .sat_cnt_o(sat_cnt_o)
`endif
    );

    int checks = 0, errors = 0;

    // ---------------- reference model ----------------
    int unsigned m_lfsr [NL];
    int          cur_shift;
    longint      m_clip;

    task automatic m_seed(input logic [47:0] s);
        int unsigned v, kk;
        for (int k = 0; k < NL; k++) begin
            kk = k + 1;
            v  = s[31:0] ^ {s[47:32], 16'h0} ^ (kk * 32'h9E3779B9);
            m_lfsr[k] = (v == 0) ? 1 : v;
        end
        m_clip = 0;
    endtask

    function automatic int unsigned m_step(input int unsigned x);
        int exps [4] = '{32, 22, 2, 1};
        int unsigned taps = 0;
        foreach (exps[i]) taps = taps | (32'h1 << (exps[i] - 1));
        return x[0] ? ((x >> 1) ^ taps) : (x >> 1);
    endfunction

    task automatic m_next(output logic [DW-1:0] w);
        int sum, y;
        w = '0;
        for (int s = 0; s < NSAMP; s++) begin
            sum = 0;
            for (int j = 0; j < NSUM; j++)
                sum += int'(m_lfsr[s*NSUM+j] >> (32 - SAMP_W)) - HALF;
            y = sum >>> cur_shift;
            if (y > HALF - 1)  begin y = HALF - 1; m_clip++; end
            else if (y < -HALF) begin y = -HALF;   m_clip++; end
            w[s*OUT_W +: OUT_W] = OUT_W'(y);
        end
        for (int k = 0; k < NL; k++) m_lfsr[k] = m_step(m_lfsr[k]);
    endtask

    // ---------------- driver / scoreboard ----------------
    logic          held_vld = 1'b0, acc_flag, last_valid;
    logic [DW-1:0] held_data, acc_word;
    int            n_acc;

    task automatic tick(input logic run, input logic rdy);
        logic [DW-1:0] exp_w;
        @(negedge clk);
        acc_flag   = 1'b0;
        last_valid = sim_valid;
        if (held_vld) begin
            checks++;
            if (sim_valid !== 1'b1 || sim_data !== held_data) begin
                errors++;
                $display("FAIL stall_hold valid=%b data=%h required valid=1 data=%h",
                         sim_valid, sim_data, held_data);
            end
        end
        held_vld = 1'b0;
        if (sim_valid === 1'b1 && rdy) begin
            m_next(exp_w);
            checks++;
            if (sim_data !== exp_w) begin
                errors++;
                $display("FAIL word%0d got %h required %h", n_acc, sim_data, exp_w);
            end
            acc_word = sim_data;
            acc_flag = 1'b1;
            n_acc++;
        end else if (sim_valid === 1'b1) begin
            held_vld  = 1'b1;
            held_data = sim_data;
        end
        run_i     = run;
        sim_ready = rdy;
    endtask

    task automatic load_seed(input logic [47:0] s);
        @(negedge clk);
        seed_i = s; seed_load_i = 1'b1; run_i = 1'b0; held_vld = 1'b0;
        @(negedge clk);
        seed_load_i = 1'b0;
        m_seed(s);
        n_acc = 0;
    endtask

    task automatic drain();
        repeat (4) tick(1'b0, 1'b1);
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n_i = 1'b0; seed_load_i = 1'b0; run_i = 1'b0; sim_ready = 1'b0;
        seed_i = '0; shift_i = 4'd2; cur_shift = 2;
        #12;
        checks++;
        if (sim_valid !== 1'b0 || sim_data !== '0) begin
            errors++;
            $display("FAIL reset_state valid=%b data=%h required 0/0", sim_valid, sim_data);
        end
        @(negedge clk);
        rst_n_i = 1'b1;
        m_seed(SEED_BASE);
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'(($urandom_range(0, 1))));
            checks++;
            if (sim_valid !== 1'b0 || sim_data !== '0) begin
                errors++;
                $display("FAIL idle_cycle%0d valid=%b data=%h required 0/0", i, sim_valid, sim_data);
            end
        end
`ifdef GAUSS_SAT_CNT_EN
        checks++;
        if (sat_cnt_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_sat_cnt got %0d required 0", sat_cnt_o);
        end
`endif
    endtask

    task automatic test_seed_run();
        load_seed(48'h000000000001);
        run_i = 1'b1; sim_ready = 1'b1;          // run_i seen at edge N
        @(negedge clk);
        checks++;
        if (sim_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_edgeN valid=%b required 0", sim_valid);
        end
        tick(1'b1, 1'b1);
        checks++;
        if (last_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_edgeN1 valid=%b required 1", last_valid);
        end
        repeat (63) tick(1'b1, 1'b1);
        checks++;
        if (n_acc != 64) begin
            errors++;
            $display("FAIL seed_run_count got %0d required 64", n_acc);
        end
        drain();
    endtask

    task automatic test_stall_toggle();
        load_seed(48'h000000000001);
        repeat (10) tick(1'b1, 1'b1);
        repeat (5)  tick(1'b1, 1'b0);
        repeat (10) tick(1'b1, 1'b1);
        repeat (200) tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        drain();
        checks++;
        if (n_acc < 40) begin
            errors++;
            $display("FAIL stall_toggle_progress got %0d required >=40", n_acc);
        end
    endtask

    task automatic test_shift0();
        int hits = 0;
        logic [OUT_W-1:0] v;
        shift_i = 4'd0; cur_shift = 0;
        load_seed(rnd48());
        repeat (150) begin
            tick(1'b1, 1'b1);
            if (acc_flag)
                for (int s = 0; s < NSAMP; s++) begin
                    v = acc_word[s*OUT_W +: OUT_W];
                    if (v == OUT_W'(HALF - 1) || v == OUT_W'(-HALF)) hits++;
                end
        end
        drain();
        checks++;
        if (hits == 0) begin
            errors++;
            $display("FAIL shift0_bound_hits got 0 required >0");
        end
`ifdef GAUSS_SAT_CNT_EN
        checks++;
        if (m_clip == 0 || sat_cnt_o !== 32'(m_clip)) begin
            errors++;
            $display("FAIL shift0_sat_cnt got %0d required %0d (>0)", sat_cnt_o, m_clip);
        end
`endif
    endtask

    task automatic test_shift15();
        int bad = 0;
        logic [OUT_W-1:0] v;
        shift_i = 4'd15; cur_shift = 15;
        load_seed(rnd48());
        repeat (42) begin
            tick(1'b1, 1'b1);
            if (acc_flag)
                for (int s = 0; s < NSAMP; s++) begin
                    v = acc_word[s*OUT_W +: OUT_W];
                    if (v != '0 && v != '1) bad++;
                end
        end
        drain();
        checks++;
        if (bad != 0 || n_acc < 40) begin
            errors++;
            $display("FAIL shift15_zero_or_m1 bad=%0d words=%0d required bad=0 words>=40", bad, n_acc);
        end
    endtask

    // Sum of four centred uniforms >>>1 spans +-4096 with sigma ~1182; clipping
    // at +-2048 removes ~8% of mass in the tails and brings sigma to ~1111.
    // Bounds are ~4 standard errors around that for 4096 words.
    task automatic test_stats();
        real sv [NSAMP], sq [NSAMP];
        real mean, sd;
        logic [NSAMP-1:0][NSAMP-1:0] differ = '0;
        logic signed [OUT_W-1:0] v, w;
        int budget = 0;
        shift_i = 4'd1; cur_shift = 1;
        for (int s = 0; s < NSAMP; s++) begin sv[s] = 0.0; sq[s] = 0.0; end
        load_seed(rnd48());
        while (n_acc < 4096 && budget < 5000) begin
            tick(1'b1, 1'b1);
            budget++;
            if (acc_flag)
                for (int a = 0; a < NSAMP; a++) begin
                    v = acc_word[a*OUT_W +: OUT_W];
                    sv[a] += real'(int'(v));
                    sq[a] += real'(int'(v)) * real'(int'(v));
                    for (int b = a + 1; b < NSAMP; b++) begin
                        w = acc_word[b*OUT_W +: OUT_W];
                        if (v != w) differ[a][b] = 1'b1;
                    end
                end
        end
        drain();
        checks++;
        if (n_acc < 4096) begin
            errors++;
            $display("FAIL stats_words got %0d required 4096", n_acc);
        end
        for (int s = 0; s < NSAMP; s++) begin
            mean = sv[s] / 4096.0;
            sd   = $sqrt(sq[s] / 4096.0 - mean * mean);
            checks++;
            if (mean > 72.0 || mean < -72.0 || sd < 1060.0 || sd > 1160.0) begin
                errors++;
                $display("FAIL stats_slot%0d mean=%0f std=%0f required |mean|<72 std 1060..1160", s, mean, sd);
            end
            for (int b = s + 1; b < NSAMP; b++) begin
                checks++;
                if (!differ[s][b]) begin
                    errors++;
                    $display("FAIL slots_identical %0d/%0d got identical required distinct", s, b);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        shift_i = 4'd2; cur_shift = 2;
        load_seed(rnd48());
        repeat (6) tick(1'b1, 1'b1);
        repeat (3) tick(1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n_i = 1'b0;
        #1;
        checks++;
        if (sim_valid !== 1'b0 || sim_data !== '0) begin
            errors++;
            $display("FAIL async_reset valid=%b data=%h required 0/0", sim_valid, sim_data);
        end
        held_vld = 1'b0;
        @(negedge clk);
        rst_n_i = 1'b1;
        m_seed(SEED_BASE);
        n_acc = 0;
        repeat (30) tick(1'b1, 1'b1);
        drain();
        checks++;
        if (n_acc < 28) begin
            errors++;
            $display("FAIL post_reset_count got %0d required >=28", n_acc);
        end
    endtask

    task automatic test_seed_in_stall();
        logic [DW-1:0] d0;
        logic [47:0]   sb = rnd48();
        load_seed(rnd48());
        repeat (5) tick(1'b1, 1'b1);
        repeat (2) tick(1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (sim_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_setup valid=%b required 1", sim_valid);
        end
        d0 = sim_data;
        seed_i = sb; seed_load_i = 1'b1; run_i = 1'b1; sim_ready = 1'b0; held_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (sim_valid !== 1'b0 || sim_data !== d0) begin
            errors++;
            $display("FAIL seed_in_stall valid=%b data=%h required 0/%h", sim_valid, sim_data, d0);
        end
`ifdef GAUSS_SAT_CNT_EN
        checks++;
        if (sat_cnt_o !== 32'h0) begin
            errors++;
            $display("FAIL seed_clears_sat got %0d required 0", sat_cnt_o);
        end
`endif
        seed_load_i = 1'b0;
        m_seed(sb);
        n_acc = 0;
        repeat (20) tick(1'b1, 1'b1);
        drain();
        checks++;
        if (n_acc < 18) begin
            errors++;
            $display("FAIL post_seed_count got %0d required >=18", n_acc);
        end
    endtask

    initial begin
        test_reset();
        test_seed_run();
        test_stall_toggle();
        test_shift0();
        test_shift15();
        test_stats();
        test_reset_mid_stall();
        test_seed_in_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
